// File: rtl/vx_barrier_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// vx_barrier_ctrl_pkg : shared types for the warp barrier scheduler
// Rev 1.0
// ============================================================================
package vx_barrier_ctrl_pkg;

    localparam int BAR_NUM_WARPS    = 4;
    localparam int BAR_NUM_BARRIERS = 4;
    localparam int BAR_NW_BITS      = $clog2(BAR_NUM_WARPS);
    localparam int BAR_NB_BITS      = (BAR_NUM_BARRIERS > 1) ? $clog2(BAR_NUM_BARRIERS) : 1;

    typedef struct packed {
        logic                     active;
        logic [BAR_NW_BITS-1:0]   size_m1;
        logic [BAR_NW_BITS-1:0]   count;
        logic [BAR_NUM_WARPS-1:0] wmask;
    } bar_state_t;

    localparam int BAR_STATE_BITS = $bits(bar_state_t);

    // Arrival request as delivered by the GPU unit, widened with the warp id.
    typedef struct packed {
        logic [BAR_NW_BITS-1:0] wid;
        logic [BAR_NB_BITS-1:0] id;
        logic [BAR_NW_BITS-1:0] size_m1;
    } bar_req_t;

    function automatic logic [BAR_NUM_WARPS-1:0] bar_wid_mask(input logic [BAR_NW_BITS-1:0] wid);
        return BAR_NUM_WARPS'(1) << wid;
    endfunction

endpackage

`ifndef BAR_STATE_BITS
`define BAR_STATE_BITS vx_barrier_ctrl_pkg::BAR_STATE_BITS
`endif
`default_nettype wire

// File: rtl/vx_barrier_slot.sv
`default_nettype none
// ============================================================================
// vx_barrier_slot : state of one barrier slot plus its last/mismatch flags
// Rev 1.0
// ============================================================================
module vx_barrier_slot
    import vx_barrier_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     arrive_i,
    input  logic [BAR_NW_BITS-1:0]   wid_i,
    input  logic [BAR_NW_BITS-1:0]   size_m1_i,
    output logic [BAR_NUM_WARPS-1:0] wmask_o,
    output logic                     last_o,
    output logic                     mismatch_o
);

    bar_state_t             state_q;
    bar_state_t             state_d;
    logic [BAR_NW_BITS-1:0] w_size;

    always_comb begin
        // An inactive slot takes its size from the arriving request.
        w_size     = state_q.active ? state_q.size_m1 : size_m1_i;
        last_o     = (state_q.count == w_size);
        mismatch_o = state_q.active && (size_m1_i != state_q.size_m1);
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = '0;
        end else if (arrive_i) begin
            if (last_o) begin
                state_d = '0;
            end else begin
                state_d.active  = 1'b1;
                state_d.size_m1 = w_size;
                state_d.count   = state_q.count + 1'b1;
                state_d.wmask   = state_q.wmask | bar_wid_mask(wid_i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign wmask_o = state_q.wmask;

endmodule
`default_nettype wire

// File: rtl/vx_barrier_ctrl.sv
`default_nettype none
// ============================================================================
// vx_barrier_ctrl : per-core warp barrier scheduler (stall, release, error)
// Rev 1.0
// ============================================================================
module vx_barrier_ctrl
    import vx_barrier_ctrl_pkg::*;
#(
    parameter int NUM_WARPS    = BAR_NUM_WARPS,
    parameter int NUM_BARRIERS = BAR_NUM_BARRIERS,
    localparam int NW_BITS     = $clog2(NUM_WARPS),
    localparam int NB_BITS     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bar_valid_i,
    input  logic [NW_BITS-1:0]   bar_wid_i,
    input  logic [NB_BITS-1:0]   bar_id_i,
    input  logic [NW_BITS-1:0]   bar_size_m1_i,
    output logic                 bar_ready_o,
    input  logic                 flush_i,
    output logic [NUM_WARPS-1:0] stall_mask_o,
    output logic                 release_valid_o,
    output logic [NUM_WARPS-1:0] release_mask_o,
    output logic                 err_o,
    output logic                 busy_o
);

    bar_req_t              w_req;
    logic                  w_accept;
    logic                  w_dup;
    logic                  w_last;
    logic [NUM_WARPS-1:0]  w_wbit;
    logic [NUM_WARPS-1:0]  w_stall;
    logic [NUM_BARRIERS-1:0] w_slot_arrive;
    logic [NUM_BARRIERS-1:0] w_slot_last;
    logic [NUM_BARRIERS-1:0] w_slot_mis;
    logic [NUM_WARPS-1:0]  w_slot_wmask [NUM_BARRIERS];

    logic                  bar_ready_q;
    logic                  release_valid_q, release_valid_d;
    logic [NUM_WARPS-1:0]  release_mask_q, release_mask_d;
    logic                  err_q, err_d;

    always_comb begin
        w_req.wid     = bar_wid_i;
        w_req.id      = bar_id_i;
        w_req.size_m1 = bar_size_m1_i;
        w_accept      = bar_valid_i & bar_ready_q;
        w_wbit        = bar_wid_mask(w_req.wid);
        w_dup         = w_stall[w_req.wid];
        w_last        = w_accept & ~w_dup & w_slot_last[w_req.id];
    end

    generate
        for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_slot
            assign w_slot_arrive[i] = w_accept & ~w_dup & ~flush_i & (w_req.id == NB_BITS'(i));

            vx_barrier_slot u_slot (
                .clk        (clk),
                .reset      (reset),
                .flush_i    (flush_i),
                .arrive_i   (w_slot_arrive[i]),
                .wid_i      (w_req.wid),
                .size_m1_i  (w_req.size_m1),
                .wmask_o    (w_slot_wmask[i]),
                .last_o     (w_slot_last[i]),
                .mismatch_o (w_slot_mis[i])
            );
        end
    endgenerate

    always_comb begin
        w_stall = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            w_stall = w_stall | w_slot_wmask[i];
        end
    end

    // Flush wins over everything: it drains all waiters, including a warp arriving this cycle.
    always_comb begin
        release_valid_d = 1'b0;
        release_mask_d  = '0;
        err_d           = 1'b0;
        if (flush_i) begin
            release_valid_d = 1'b1;
            release_mask_d  = w_stall | (w_accept ? w_wbit : '0);
        end else begin
            if (w_last) begin
                release_valid_d = 1'b1;
                release_mask_d  = w_slot_wmask[w_req.id] | w_wbit;
            end
            err_d = w_accept & (w_dup | w_slot_mis[w_req.id]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bar_ready_q     <= 1'b0;
            release_valid_q <= 1'b0;
            release_mask_q  <= '0;
            err_q           <= 1'b0;
        end else begin
            bar_ready_q     <= 1'b1;
            release_valid_q <= release_valid_d;
            release_mask_q  <= release_mask_d;
            err_q           <= err_d;
        end
    end

    assign bar_ready_o     = bar_ready_q;
    assign stall_mask_o    = w_stall;
    assign release_valid_o = release_valid_q;
    assign release_mask_o  = release_mask_q;
    assign err_o           = err_q;
    assign busy_o          = |w_stall;

endmodule
`default_nettype wire

// File: tb/tb_vx_barrier_ctrl.sv
`default_nettype none
// ============================================================================
// tb_vx_barrier_ctrl : scoreboard bench for the warp barrier scheduler
// Rev 1.0
// ============================================================================
module tb_vx_barrier_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bar_valid = 1'b0;
    logic [1:0] bar_wid = '0;
    logic [1:0] bar_id = '0;
    logic [1:0] bar_size_m1 = '0;
    logic       flush = 1'b0;
    logic       bar_ready;
    logic [3:0] stall_mask;
    logic       release_valid;
    logic [3:0] release_mask;
    logic       err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       rv;
        logic [3:0] rm;
        logic [3:0] sm;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;

    vx_barrier_ctrl #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .bar_valid_i     (bar_valid),
        .bar_wid_i       (bar_wid),
        .bar_id_i        (bar_id),
        .bar_size_m1_i   (bar_size_m1),
        .bar_ready_o     (bar_ready),
        .flush_i         (flush),
        .stall_mask_o    (stall_mask),
        .release_valid_o (release_valid),
        .release_mask_o  (release_mask),
        .err_o           (err),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Each expectation is due one clock edge after its stimulus was driven.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            checks += 5;
            if (release_valid !== cur.rv) begin
                errors++;
                $display("FAIL %s release_valid: got %b expected %b", cur.name, release_valid, cur.rv);
            end
            if (release_mask !== cur.rm) begin
                errors++;
                $display("FAIL %s release_mask: got %b expected %b", cur.name, release_mask, cur.rm);
            end
            if (stall_mask !== cur.sm) begin
                errors++;
                $display("FAIL %s stall_mask: got %b expected %b", cur.name, stall_mask, cur.sm);
            end
            if (err !== cur.err) begin
                errors++;
                $display("FAIL %s err: got %b expected %b", cur.name, err, cur.err);
            end
            if (bar_ready !== cur.rdy) begin
                errors++;
                $display("FAIL %s bar_ready: got %b expected %b", cur.name, bar_ready, cur.rdy);
            end
        end
    end

    task automatic drive(input string nm, input logic rst, input logic v, input logic [1:0] w,
                         input logic [1:0] b, input logic [1:0] s, input logic fl,
                         input logic erv, input logic [3:0] erm, input logic [3:0] esm,
                         input logic eerr, input logic erdy);
        @(negedge clk);
        reset       = rst;
        bar_valid   = v;
        bar_wid     = w;
        bar_id      = b;
        bar_size_m1 = s;
        flush       = fl;
        sb_q.push_back('{nm, erv, erm, esm, eerr, erdy});
    endtask

    task automatic idle(input string nm);
        drive(nm, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        drive("rst0", 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive("rst1", 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (bar_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_busy: got ready=%b busy=%b expected 0 0", bar_ready, busy);
        end
        // Ready is still low on the first cycle out of reset, so this arrival is ignored.
        drive("not_ready", 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        idle("post_reset_idle");
    endtask

    task automatic test_release_all();
        drive("ra_w0", 1'b0, 1'b1, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        drive("ra_w1", 1'b0, 1'b1, 2'd1, 2'd1, 2'd3, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1);
        drive("ra_w2", 1'b0, 1'b1, 2'd2, 2'd1, 2'd3, 1'b0, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ra_busy: got %b expected 1", busy);
        end
        drive("ra_w3", 1'b0, 1'b1, 2'd3, 2'd1, 2'd3, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
        idle("ra_idle");
    endtask

    task automatic test_single();
        drive("single_w2", 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1);
        idle("single_idle");
    endtask

    task automatic test_independent();
        drive("ind_w0b0", 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        drive("ind_w1b2", 1'b0, 1'b1, 2'd1, 2'd2, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1);
        drive("ind_w2b2", 1'b0, 1'b1, 2'd2, 2'd2, 2'd1, 1'b0, 1'b1, 4'b0110, 4'b0001, 1'b0, 1'b1);
        drive("ind_w3b0", 1'b0, 1'b1, 2'd3, 2'd0, 2'd1, 1'b0, 1'b1, 4'b1001, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic test_errors();
        drive("err_first", 1'b0, 1'b1, 2'd1, 2'd3, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1);
        drive("err_dup",   1'b0, 1'b1, 2'd1, 2'd3, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b1);
        drive("err_size",  1'b0, 1'b1, 2'd2, 2'd3, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b1, 1'b1);
        // Releases only if the duplicate left count at 1 and the mismatch was counted.
        drive("err_last",  1'b0, 1'b1, 2'd0, 2'd3, 2'd2, 1'b0, 1'b1, 4'b0111, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        drive("fl_w0",    1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        drive("fl_w2",    1'b0, 1'b1, 2'd2, 2'd2, 2'd3, 1'b0, 1'b0, 4'b0000, 4'b0101, 1'b0, 1'b1);
        drive("fl_arr",   1'b0, 1'b1, 2'd1, 2'd1, 2'd3, 1'b1, 1'b1, 4'b0111, 4'b0000, 1'b0, 1'b1);
        drive("fl_empty", 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drive("fl_re_w0", 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        drive("fl_re_w1", 1'b0, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0, 1'b1, 4'b0011, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        drive("rm_w0",  1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        drive("rm_w1",  1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1);
        drive("rm_rst", 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        idle("rm_idle");
        drive("rm_w2",  1'b0, 1'b1, 2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1);
        drive("rm_w3",  1'b0, 1'b1, 2'd3, 2'd1, 2'd1, 1'b0, 1'b1, 4'b1100, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        drive("b2b_w0", 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
        drive("b2b_w1", 1'b0, 1'b1, 2'd1, 2'd1, 2'd0, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1);
        drive("b2b_w2", 1'b0, 1'b1, 2'd2, 2'd2, 2'd1, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1);
        drive("b2b_w3", 1'b0, 1'b1, 2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 4'b1000, 4'b0100, 1'b0, 1'b1);
        drive("b2b_w1b", 1'b0, 1'b1, 2'd1, 2'd2, 2'd1, 1'b0, 1'b1, 4'b0110, 4'b0000, 1'b0, 1'b1);
        idle("b2b_idle");
    endtask

    initial begin
        test_reset();
        test_release_all();
        test_single();
        test_independent();
        test_errors();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
